// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: operand/result widths, op codes,
// FSM encoding and the packed queue entry layout.
package alu_pkg;

   localparam int OPND_W = 4;
   localparam int RES_W  = 8;
   localparam int OP_W   = 3;
   localparam int CMD_W  = 2 * OPND_W + OP_W;

   localparam logic [OP_W-1:0] OP_AND = 3'd0;
   localparam logic [OP_W-1:0] OP_ADD = 3'd1;
   localparam logic [OP_W-1:0] OP_SUB = 3'd2;
   localparam logic [OP_W-1:0] OP_OR  = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR = 3'd4;
   localparam logic [OP_W-1:0] OP_MUL = 3'd5;
   localparam logic [OP_W-1:0] OP_CAT = 3'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef struct packed {
      logic [OPND_W-1:0] a;
      logic [OPND_W-1:0] b;
      logic [OP_W-1:0]   op;
   } cmd_t;

   // Code 7 is undefined on the ALU and is folded onto code 0.
   function automatic logic [OP_W-1:0] norm_op(input logic [OP_W-1:0] op);
      return (op == 3'd7) ? OP_AND : op;
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue: power-of-two depth, pointers carry one extra bit so that
// full and empty are told apart when the index bits match.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = CMD_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, issues one at a time to a fixed-latency ALU and holds the
// captured result until downstream takes it. Handshakes: a transfer happens on a
// rising edge where valid and ready are both high; valid keeps its payload until then.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int ALU_LATENCY = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic [2:0] cmd_op,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [7:0] alu_result,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [2:0] res_op,
   output logic [7:0] res_count,
   output logic       busy,
   output logic [1:0] fsm_state
);

   localparam logic [2:0] LAT_LAST = 3'(ALU_LATENCY - 1);

   state_t           state_q;
   state_t           state_d;
   logic [2:0]       lat_cnt;
   logic             lat_done;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             capture;
   logic             release_res;
   logic [CMD_W-1:0] fifo_din;
   logic [CMD_W-1:0] fifo_dout;
   cmd_t             head;

   assign cmd_ready = !full && !reset;
   assign push      = cmd_valid && cmd_ready;
   assign fifo_din  = {cmd_a, cmd_b, cmd_op};
   assign head      = cmd_t'(fifo_dout);
   assign lat_done  = (lat_cnt == LAT_LAST);
   assign busy      = (state_q != IDLE) || !empty;
   assign fsm_state = state_q;

   alu_cmd_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(CMD_W)
   ) u_fifo (
      .clock(clock),
      .reset(reset),
      .push (push),
      .pop  (pop),
      .din  (fifo_din),
      .dout (fifo_dout),
      .full (full),
      .empty(empty)
   );

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!empty)   state_d = WAIT;
         WAIT:    if (lat_done) state_d = HOLD;
         HOLD:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop         = 1'b0;
      capture     = 1'b0;
      release_res = 1'b0;
      case (state_q)
         IDLE:    pop         = !empty;
         WAIT:    capture     = lat_done;
         HOLD:    release_res = res_ready;
         default: ;
      endcase
   end

   // The empty flag is registered, so a freshly pushed command is popped one edge later.
   always_ff @(posedge clock) begin
      if (reset) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         lat_cnt   <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_op    <= '0;
         res_count <= '0;
      end else begin
         if (pop) begin
            alu_a   <= head.a;
            alu_b   <= head.b;
            alu_op  <= norm_op(head.op);
            lat_cnt <= '0;
         end else if (state_q == WAIT) begin
            lat_cnt <= lat_cnt + 3'd1;
         end
         if (capture) begin
            res_data  <= alu_result;
            res_op    <= alu_op;
            res_valid <= 1'b1;
         end
         if (release_res) begin
            res_valid <= 1'b0;
            res_count <= res_count + 8'd1;
         end
      end
   end

endmodule
